// File: rtl/wb_writer.sv
// ---------------------------------------------------------------------------
// wb_writer -- writeback-stage writer for the register-file write port.
//
// Registers the MEM-stage result, formats load data (byte / halfword
// extraction with sign or zero extension) and buffers results from the
// long-latency multiply/divide unit in a 2-entry FIFO. One register-file
// write is issued per cycle: in-order pipeline writes always win, queued
// results drain in cycles the pipeline leaves free.
//
// Optional feature (macro WB_WAW_SQUASH_EN):
//   When defined, a pipeline write to register A invalidates every queued
//   entry for A (including one accepted in the same cycle), since queued
//   results are always older. Invalid entries are popped without a write.
//   When undefined, every accepted entry is eventually written.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   m_valid, m_wen  MEM-stage instruction valid / writes a GPR
//   m_waddr         MEM-stage destination GPR
//   m_result        ALU/address result for non-loads
//   m_is_load       use formatted m_rdata instead of m_result
//   m_load_type     0=LW 1=LB 2=LBU 3=LH 4=LHU (5..7 write m_result)
//   m_byte_off      effective address bits [1:0]
//   m_rdata         data memory read word, little-endian
//   x_valid         long-latency unit offers a result
//   x_waddr, x_data its destination GPR and result
//   x_ready         queue accepts this cycle (combinational)
//   w_w_ena/addr/data  register-file write port (registered)
//   wb_pending      number of stored queue entries (registered)
// ---------------------------------------------------------------------------
module wb_writer #(
    parameter int QDEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m_valid,
    input  logic        m_wen,
    input  logic [4:0]  m_waddr,
    input  logic [31:0] m_result,
    input  logic        m_is_load,
    input  logic [2:0]  m_load_type,
    input  logic [1:0]  m_byte_off,
    input  logic [31:0] m_rdata,
    input  logic        x_valid,
    input  logic [4:0]  x_waddr,
    input  logic [31:0] x_data,
    output logic        x_ready,
    output logic        w_w_ena,
    output logic [4:0]  w_w_addr,
    output logic [31:0] w_w_data,
    output logic [1:0]  wb_pending
);

    localparam logic [1:0] FULL = 2'(QDEPTH);

    localparam logic [2:0] LT_LW  = 3'd0;
    localparam logic [2:0] LT_LB  = 3'd1;
    localparam logic [2:0] LT_LBU = 3'd2;
    localparam logic [2:0] LT_LH  = 3'd3;
    localparam logic [2:0] LT_LHU = 3'd4;

    // -----------------------------------------------------------------------
    // Load-data formatting helpers
    // -----------------------------------------------------------------------
    function automatic logic [31:0] sext8(input logic [7:0] b);
        logic signed [7:0] s;
        s = b;
        return 32'(s);
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] h);
        logic signed [15:0] s;
        s = h;
        return 32'(s);
    endfunction

    function automatic logic [31:0] fmt_load(
        input logic [2:0]  lt,
        input logic [1:0]  off,
        input logic [31:0] rd,
        input logic [31:0] res
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{off, 3'b000} +: 8];
        // off[0] is ignored for halfwords; misalignment is trapped upstream.
        h = off[1] ? rd[31:16] : rd[15:0];
        case (lt)
            LT_LW:   fmt_load = rd;
            LT_LB:   fmt_load = sext8(b);
            LT_LBU:  fmt_load = {24'd0, b};
            LT_LH:   fmt_load = sext16(h);
            LT_LHU:  fmt_load = {16'd0, h};
            default: fmt_load = res;
        endcase
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  qv_q, qv_d;          // per-slot "still to be written" flag
    logic [4:0]  qa_q [2];
    logic [4:0]  qa_d [2];
    logic [31:0] qd_q [2];
    logic [31:0] qd_d [2];

    logic        w_ena_q, w_ena_d;
    logic [4:0]  w_addr_q, w_addr_d;
    logic [31:0] w_data_q, w_data_d;

    logic        pipe_req;
    logic        push_acc;
    logic        push_store;
    logic        push_v;
    logic        pop;
    logic        head_v;
    logic [31:0] pipe_data;

    // Ready looks only at the count before this cycle's pop, so a full
    // queue refuses a push even in a cycle that drains an entry.
    assign x_ready = !rst && (count_q < FULL);

    // -----------------------------------------------------------------------
    // Request decode
    // -----------------------------------------------------------------------
    always_comb begin
        pipe_req   = m_valid && m_wen && (m_waddr != 5'd0);
        push_acc   = x_valid && x_ready;
        // Results for x0 are acknowledged but never stored.
        push_store = push_acc && (x_waddr != 5'd0);
        // Any stored entry (valid or squashed) is popped when the pipeline
        // leaves the port free; a squashed pop still consumes the cycle.
        pop        = !pipe_req && (count_q != 2'd0);
        head_v     = qv_q[rd_ptr_q];
        pipe_data  = m_is_load ? fmt_load(m_load_type, m_byte_off, m_rdata, m_result)
                               : m_result;
    end

    // -----------------------------------------------------------------------
    // Queue next state
    // -----------------------------------------------------------------------
    always_comb begin
        qv_d     = qv_q;
        qa_d     = qa_q;
        qd_d     = qd_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        push_v   = 1'b1;

`ifdef WB_WAW_SQUASH_EN
        if (pipe_req) begin
            for (int i = 0; i < 2; i++) begin
                if (qa_q[i] == m_waddr) begin
                    qv_d[i] = 1'b0;
                end
            end
            // A result arriving now is older than this pipeline write.
            if (x_waddr == m_waddr) begin
                push_v = 1'b0;
            end
        end
`endif

        if (pop) begin
            qv_d[rd_ptr_q] = 1'b0;
            rd_ptr_d       = ~rd_ptr_q;
        end

        if (push_store) begin
            qv_d[wr_ptr_q] = push_v;
            qa_d[wr_ptr_q] = x_waddr;
            qd_d[wr_ptr_q] = x_data;
            wr_ptr_d       = ~wr_ptr_q;
        end

        count_d = count_q + {1'b0, push_store} - {1'b0, pop};
    end

    // -----------------------------------------------------------------------
    // Write-port arbitration
    // -----------------------------------------------------------------------
    always_comb begin
        w_ena_d  = 1'b0;
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;
        if (pipe_req) begin
            w_ena_d  = 1'b1;
            w_addr_d = m_waddr;
            w_data_d = pipe_data;
        end else if (pop && head_v) begin
            w_ena_d  = 1'b1;
            w_addr_d = qa_q[rd_ptr_q];
            w_data_d = qd_q[rd_ptr_q];
        end
    end

    // -----------------------------------------------------------------------
    // Registers: control and output port (reset), queue payload (no reset)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            qv_q     <= 2'b00;
            w_ena_q  <= 1'b0;
            w_addr_q <= 5'd0;
            w_data_q <= 32'd0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            qv_q     <= qv_d;
            w_ena_q  <= w_ena_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
        end
    end

    always_ff @(posedge clk) begin
        qa_q <= qa_d;
        qd_q <= qd_d;
    end

    assign w_w_ena    = w_ena_q;
    assign w_w_addr   = w_addr_q;
    assign w_w_data   = w_data_q;
    assign wb_pending = count_q;

endmodule
